// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined carry adder.
// Provides the default operand width and pipeline depth, the slice-width
// derivation, and the parameter-legality predicate used at elaboration.
package pipe_adder_pkg;

  localparam int unsigned DefaultWidth  = 64;
  localparam int unsigned DefaultStages = 4;

  // Bits handled by each pipeline slice.
  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // Width must split into equal, non-empty slices.
  function automatic bit params_legal(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple-carry slice of SliceWidth bits.
// Ports:
//   a, b  - slice operands
//   cin   - carry into bit 0
//   s     - slice sum
//   cout  - carry out of the top bit
//   cmsb  - carry into the top bit (for two's-complement overflow)
module adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int unsigned SliceWidth = slice_width(DefaultWidth, DefaultStages)
) (
  input  logic [SliceWidth-1:0] a,
  input  logic [SliceWidth-1:0] b,
  input  logic                  cin,
  output logic [SliceWidth-1:0] s,
  output logic                  cout,
  output logic                  cmsb
);

  logic [SliceWidth:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < SliceWidth; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SliceWidth];
  assign cmsb = c[SliceWidth-1];

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES equal slices,
// one slice added per stage, carry and partial sum registered between them.
// Latency STAGES cycles, one result per cycle, global stall on the output.
// Optional feature macro: PIPE_ADDER_SUB_EN adds the sub port (subtract select).
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid, in_ready  - input handshake
//   in1, in2, c_in      - operands and carry-in
//   sub                 - subtract select (PIPE_ADDER_SUB_EN only)
//   out_valid, out_ready- output handshake
//   sum, c_out, overflow- result, carry-out, two's-complement overflow
module pipelined_carry_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned STAGES = DefaultStages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned SW = slice_width(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : gen_param_check
    $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic sub_sel;
`ifdef PIPE_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Subtraction is folded in at the input: B is inverted once and the
  // inverted operand travels down the pipeline with its slice.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             advance;

  assign b_eff    = in2 ^ {WIDTH{sub_sel}};
  assign cin_eff  = c_in ^ sub_sel;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    localparam int unsigned Lo = k * SW;
    localparam int unsigned Hi = Lo + SW;

    // Operand bits not yet added; the low SW bits feed this stage's slice.
    logic [WIDTH-Lo-1:0] a_pend;
    logic [WIDTH-Lo-1:0] b_pend;
    logic [Hi-1:0]       sum_d;
    logic [Hi-1:0]       sum_q;
    logic [SW-1:0]       s_slice;
    logic                cin_slice;
    logic                cout_slice;
    logic                cmsb_slice;
    logic                valid_d;
    logic                valid_q;
    logic                carry_q;

    if (k == 0) begin : gen_head
      assign a_pend    = in1;
      assign b_pend    = b_eff;
      assign cin_slice = cin_eff;
      assign valid_d   = in_valid;
      assign sum_d     = s_slice;
    end else begin : gen_body
      assign a_pend    = gen_stage[k-1].gen_carry.a_up_q;
      assign b_pend    = gen_stage[k-1].gen_carry.b_up_q;
      assign cin_slice = gen_stage[k-1].carry_q;
      assign valid_d   = gen_stage[k-1].valid_q;
      assign sum_d     = {s_slice, gen_stage[k-1].sum_q};
    end

    adder_slice #(
      .SliceWidth(SW)
    ) u_slice (
      .a   (a_pend[SW-1:0]),
      .b   (b_pend[SW-1:0]),
      .cin (cin_slice),
      .s   (s_slice),
      .cout(cout_slice),
      .cmsb(cmsb_slice)
    );

    // Bubbles are kept: every register loads or holds together.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= valid_d;
        carry_q <= cout_slice;
        sum_q   <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : gen_carry
      logic [WIDTH-Hi-1:0] a_up_q;
      logic [WIDTH-Hi-1:0] b_up_q;
      logic                unused_cmsb;

      // Only the final slice's MSB carry matters for overflow.
      assign unused_cmsb = cmsb_slice;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_up_q <= '0;
          b_up_q <= '0;
        end else if (advance) begin
          a_up_q <= a_pend[WIDTH-Lo-1:SW];
          b_up_q <= b_pend[WIDTH-Lo-1:SW];
        end
      end
    end else begin : gen_last
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= cmsb_slice ^ cout_slice;
        end
      end
    end
  end

  assign out_valid = gen_stage[STAGES-1].valid_q;
  assign sum       = gen_stage[STAGES-1].sum_q;
  assign c_out     = gen_stage[STAGES-1].carry_q;
  assign overflow  = gen_stage[STAGES-1].gen_last.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed self-checking bench for pipelined_carry_adder (WIDTH=64, STAGES=4).
// Sub-mode vectors are exercised when PIPE_ADDER_SUB_EN is defined.
module tb_pipelined_carry_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in1;
  logic [63:0] in2;
  logic        c_in;
`ifdef PIPE_ADDER_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        c_out;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  pipelined_carry_adder #(
    .WIDTH (64),
    .STAGES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .c_in     (c_in),
`ifdef PIPE_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation (out_ready assumed high) and check its result.
  task automatic issue_and_collect(input string tag, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic [63:0] exp_sum,
                                   input logic exp_c, input logic exp_ov);
    bit seen;
    seen     = 1'b0;
    in1      = a;
    in2      = b;
    c_in     = ci;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, 64'(c_out), 64'(exp_c));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ov));
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
  endtask

  logic [63:0] got_q[$];
  logic [63:0] exp_q[4];
  logic [63:0] got_v;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    c_in      = 1'b0;
    out_ready = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
    sub       = 1'b0;
`endif
    repeat (2) @(negedge clk);

    // Reset state; out_ready low so in_ready reflects an empty output.
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", 64'(c_out), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Latency and back-to-back throughput.
    in1      = 64'd12765438912345;
    in2      = 64'd98345672198765;
    c_in     = 1'b0;
    in_valid = 1'b1;
    check("lat_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in1  = 64'd98765678912345;
    in2  = 64'd12345432198765;
    c_in = 1'b1;
    check("lat_e1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_e2_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_e3_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_e4_valid", 64'(out_valid), 64'd1);
    check("lat_e4_sum", sum, 64'd111111111111110);
    check("lat_e4_cout", 64'(c_out), 64'd0);
    @(negedge clk);
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_sum", sum, 64'd111111111111111);
    check("b2b_cout", 64'(c_out), 64'd0);
    @(negedge clk);
    check("b2b_bubble", 64'(out_valid), 64'd0);

    // Wraparound and overflow boundaries.
    issue_and_collect("wrap0", 64'd18446744073709000006, 64'd551610, 1'b0, 64'd0, 1'b1, 1'b0);
    issue_and_collect("wrap1", 64'd18446744073709000006, 64'd551610, 1'b1, 64'd1, 1'b1, 1'b0);
    issue_and_collect("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                      64'h8000_0000_0000_0000, 1'b0, 1'b1);
    issue_and_collect("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                      64'd0, 1'b1, 1'b1);
    issue_and_collect("slice_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
                      64'h0000_0001_0000_0000, 1'b0, 1'b0);

    // Stall: three ops stream in with out_ready low, a fourth is offered
    // during the stall and must wait.
    exp_q[0] = 64'd3;
    exp_q[1] = 64'd301;
    exp_q[2] = 64'h0000_0001_0000_0000;
    exp_q[3] = 64'h0001_0000_0000_0000;
    out_ready = 1'b0;
    in1 = 64'd1; in2 = 64'd2; c_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in1 = 64'd100; in2 = 64'd200; c_in = 1'b1;
    @(negedge clk);
    in1 = 64'h0000_0000_FFFF_FFFF; in2 = 64'd1; c_in = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in1 = 64'h0000_FFFF_FFFF_FFFF; in2 = 64'd1; c_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_sum", sum, exp_q[0]);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) in_valid = 1'b0;
      if (out_valid) got_q.push_back(sum);
      @(negedge clk);
    end
    check("stall_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      got_v = (i < got_q.size()) ? got_q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
      check($sformatf("stall_order%0d", i), got_v, exp_q[i]);
    end

    // Reset with two operations in flight.
    in1 = 64'd11; in2 = 64'd22; c_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in1 = 64'd33; in2 = 64'd44;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", sum, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_stale", 64'(out_valid), 64'd0);
    end

`ifdef PIPE_ADDER_SUB_EN
    sub = 1'b1;
    issue_and_collect("sub_5m7", 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    issue_and_collect("sub_7m5", 64'd7, 64'd5, 1'b0, 64'd2, 1'b1, 1'b0);
    issue_and_collect("sub_7m5m1", 64'd7, 64'd5, 1'b1, 64'd1, 1'b1, 1'b0);
    sub = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
